// File: rtl/lock_key_loader_if.sv
// ----------------------------------------------------------------------------
// lock_key_loader_if
//   Bundles the key-store fetch port and the parallel key bus of
//   lock_key_loader into one interface.
//
//   master : the loader side. It drives ks_req and the key bus, and it samples
//            reload, ks_vld and ks_bit.
//   slave  : the environment side. This is the key store plus the locked
//            controller.
//
//   Signals
//     reload     1-cycle pulse: discard the key and fetch again
//     ks_req     fetch request to the key store
//     ks_vld     key-store beat valid
//     ks_bit     serial key data, qualified by ks_vld
//     key_out    KEY_W-bit key to the locked design (0 unless key_valid)
//     key_valid  key_out holds a parity-checked key
//     dut_hold   1 = keep the locked design in reset
//     key_error  retries exhausted
// ----------------------------------------------------------------------------
interface lock_key_loader_if #(
    parameter int unsigned KEY_W = 8
);
    logic             reload;
    logic             ks_req;
    logic             ks_vld;
    logic             ks_bit;
    logic [KEY_W-1:0] key_out;
    logic             key_valid;
    logic             dut_hold;
    logic             key_error;

    modport master (
        input  reload,
        input  ks_vld,
        input  ks_bit,
        output ks_req,
        output key_out,
        output key_valid,
        output dut_hold,
        output key_error
    );

    modport slave (
        output reload,
        output ks_vld,
        output ks_bit,
        input  ks_req,
        input  key_out,
        input  key_valid,
        input  dut_hold,
        input  key_error
    );
endinterface

// File: rtl/lock_key_loader.sv
// ----------------------------------------------------------------------------
// lock_key_loader
//   This block is the key-delivery end of the logic-locking key interface.
//   - It fetches the unlock key bit-serially from an off-block key store.
//   - It checks even parity over the whole frame.
//   - It presents the key in parallel to the locked FSM controller.
//   - The locked design is held in reset (dut_hold) until a verified key is
//     on the bus.
//   - A failed fetch is retried, up to MAX_RETRY attempts in total.
//
//   Frame: KEY_W key bits LSB first, then one even-parity bit. The XOR of
//   all KEY_W+1 bits must be 0.
//
//   Parameters
//     KEY_W      key width in bits (1..32)
//     MAX_RETRY  failed fetches allowed before the error state (>= 1)
//     TIMEOUT    max cycles between ks_vld beats while fetching (>= 2)
//
//   Ports
//     clk   clock, rising edge
//     rst   asynchronous, active-high reset
//     bus   lock_key_loader_if.master (reload, ks_req, ks_vld, ks_bit,
//           key_out, key_valid, dut_hold, key_error)
//
//   Build option
//     LOCK_KEY_LOADER_LOCKOUT_EN
//       defined   : the error state is sticky. reload is ignored there, and
//                   only rst exits it.
//       undefined : reload in the error state clears key_error and the retry
//                   count, then starts a new fetch.
//
//   All outputs are registered. Each is decoded from the next state, so
//   ks_req falls on the same edge that samples the parity beat. key_valid
//   rises as CHECK hands over to DONE.
// ----------------------------------------------------------------------------
module lock_key_loader #(
    parameter int unsigned KEY_W     = 8,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic               clk,
    input  logic               rst,
    lock_key_loader_if.master  bus
);

    // Counter widths
    localparam int unsigned CW = $clog2(KEY_W + 1);
    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam int unsigned RW = $clog2(MAX_RETRY + 1);

    localparam logic [CW-1:0] LAST_BEAT  = CW'(KEY_W);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StCheck,
        StDone,
        StFail
    } state_e;

    state_e           state_q,     state_d;
    logic [CW-1:0]    bit_cnt_q,   bit_cnt_d;
    logic [TW-1:0]    tmo_cnt_q,   tmo_cnt_d;
    logic [RW-1:0]    retry_cnt_q, retry_cnt_d;
    logic [KEY_W-1:0] shadow_q,    shadow_d;
    logic             parity_q,    parity_d;
    logic             tmo_fail_q,  tmo_fail_d;

    // Registered outputs
    logic             ks_req_q,    ks_req_d;
    logic [KEY_W-1:0] key_out_q,   key_out_d;
    logic             key_valid_q, key_valid_d;
    logic             dut_hold_q,  dut_hold_d;
    logic             key_error_q, key_error_d;

    logic             frame_ok;

    // A timed-out fetch is handled as a parity failure
    assign frame_ok = !parity_q && !tmo_fail_q;

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        retry_cnt_d = retry_cnt_q;
        shadow_d    = shadow_q;
        parity_d    = parity_q;
        tmo_fail_d  = tmo_fail_q;

        unique case (state_q)
            StIdle: begin
                bit_cnt_d  = '0;
                tmo_cnt_d  = '0;
                shadow_d   = '0;
                parity_d   = 1'b0;
                tmo_fail_d = 1'b0;
                state_d    = StShift;
            end

            StShift: begin
                // A beat is tested before the timeout, so a final beat that
                // arrives on the expiry cycle is still accepted.
                if (bus.ks_vld) begin
                    tmo_cnt_d = '0;
                    parity_d  = parity_q ^ bus.ks_bit;
                    if (bit_cnt_q == LAST_BEAT) begin
                        state_d = StCheck;
                    end else begin
                        // shadow is cleared in IDLE, so OR-ing sets one bit
                        shadow_d  = shadow_q | (KEY_W'(bus.ks_bit) << bit_cnt_q);
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    tmo_fail_d = 1'b1;
                    state_d    = StCheck;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end

            StCheck: begin
                if (frame_ok) begin
                    retry_cnt_d = '0;
                    state_d     = StDone;
                end else if (retry_cnt_q < RETRY_LAST) begin
                    // Only increments below the limit, so it saturates
                    retry_cnt_d = retry_cnt_q + RW'(1);
                    state_d     = StIdle;
                end else begin
                    state_d = StFail;
                end
            end

            StDone: begin
                if (bus.reload) begin
                    state_d = StIdle;
                end
            end

            StFail: begin
`ifdef LOCK_KEY_LOADER_LOCKOUT_EN
                state_d = StFail;
`else
                if (bus.reload) begin
                    retry_cnt_d = '0;
                    state_d     = StIdle;
                end
`endif
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Each output is decoded from the state being entered, so it
        // changes on the same edge as the state.
        ks_req_d    = (state_d == StShift);
        key_valid_d = (state_d == StDone);
        dut_hold_d  = (state_d != StDone);
        key_error_d = (state_d == StFail);
        key_out_d   = (state_d == StDone) ? shadow_d : '0;
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            retry_cnt_q <= '0;
            shadow_q    <= '0;
            parity_q    <= 1'b0;
            tmo_fail_q  <= 1'b0;
            ks_req_q    <= 1'b0;
            key_out_q   <= '0;
            key_valid_q <= 1'b0;
            dut_hold_q  <= 1'b1;
            key_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            shadow_q    <= shadow_d;
            parity_q    <= parity_d;
            tmo_fail_q  <= tmo_fail_d;
            ks_req_q    <= ks_req_d;
            key_out_q   <= key_out_d;
            key_valid_q <= key_valid_d;
            dut_hold_q  <= dut_hold_d;
            key_error_q <= key_error_d;
        end
    end

    assign bus.ks_req    = ks_req_q;
    assign bus.key_out   = key_out_q;
    assign bus.key_valid = key_valid_q;
    assign bus.dut_hold  = dut_hold_q;
    assign bus.key_error = key_error_q;

endmodule

// File: tb/tb_lock_key_loader.sv
// ----------------------------------------------------------------------------
// tb_lock_key_loader
//   Directed bench for lock_key_loader (KEY_W=8, MAX_RETRY=3, TIMEOUT=16).
//   Stimulus pushes the expected outcome of every fetch into a queue. A
//   negedge monitor pops one entry each time key_valid or key_error rises
//   and checks the key bus against it.
// ----------------------------------------------------------------------------
module tb_lock_key_loader;

    localparam int unsigned KEY_W = 8;

    typedef struct {
        logic       is_err;
        logic [7:0] key;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    exp_t exp_q[$];

    lock_key_loader_if #(.KEY_W(KEY_W)) bus ();

    lock_key_loader #(
        .KEY_W    (KEY_W),
        .MAX_RETRY(3),
        .TIMEOUT  (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (bus.ks_req) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_req: ks_req=0 after 64 cycles, required 1");
        end
    endtask

    // Sends nbeats beats (key bits LSB first, then par). A gap of idle cycles
    // is inserted before the last beat sent. reload is pulsed alongside beat
    // reload_at (-1 means no pulse).
    task automatic send_frame(input logic [7:0] key, input logic par, input int nbeats,
                              input int gap, input int reload_at);
        bit ok;
        wait_req(ok);
        if (ok) begin
            for (int i = 0; i < nbeats; i++) begin
                if (i == nbeats - 1 && gap > 0) begin
                    bus.ks_vld = 1'b0;
                    bus.reload = 1'b0;
                    repeat (gap) tick();
                end
                bus.ks_vld = 1'b1;
                bus.ks_bit = (i < 8) ? key[i] : par;
                bus.reload = (i == reload_at);
                tick();
            end
        end
        bus.ks_vld = 1'b0;
        bus.ks_bit = 1'b0;
        bus.reload = 1'b0;
    endtask

    task automatic pulse_reload();
        bus.reload = 1'b1;
        tick();
        bus.reload = 1'b0;
    endtask

    task automatic push_exp(input logic is_err, input logic [7:0] key);
        exp_t e;
        e.is_err = is_err;
        e.key    = key;
        exp_q.push_back(e);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ks_req"},    32'(bus.ks_req),    0);
        chk({tag, "_key_out"},   32'(bus.key_out),   0);
        chk({tag, "_key_valid"}, 32'(bus.key_valid), 0);
        chk({tag, "_dut_hold"},  32'(bus.dut_hold),  1);
        chk({tag, "_key_error"}, 32'(bus.key_error), 0);
    endtask

    // Scoreboard monitor
    logic prev_valid;
    logic prev_err;
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_err   = 1'b0;
        end else begin
            if (!bus.key_valid && bus.key_out != '0) begin
                chk("mon_key_out_zero_when_invalid", 32'(bus.key_out), 0);
            end
            if ((bus.key_valid && !prev_valid) || (bus.key_error && !prev_err)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon_unexpected: valid=%0b error=%0b key=%0h, required no event",
                             bus.key_valid, bus.key_error, bus.key_out);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("mon_key_error", 32'(bus.key_error), 32'(e.is_err));
                    chk("mon_key_valid", 32'(bus.key_valid), 32'(!e.is_err));
                    chk("mon_key_out",   32'(bus.key_out),   e.is_err ? 0 : 32'(e.key));
                    chk("mon_dut_hold",  32'(bus.dut_hold),  32'(e.is_err));
                end
            end
            prev_valid = bus.key_valid;
            prev_err   = bus.key_error;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit any_req;
        errors     = 0;
        checks     = 0;
        rst        = 1'b1;
        bus.reload = 1'b0;
        bus.ks_vld = 1'b0;
        bus.ks_bit = 1'b0;
        repeat (3) tick();
        chk_reset_vals("reset");
        rst = 1'b0;

        // 1: good A5 load, key_valid two cycles after the parity beat
        push_exp(1'b0, 8'hA5);
        send_frame(8'hA5, 1'b0, 9, 0, -1);
        chk("t1_check_valid", 32'(bus.key_valid), 0);
        chk("t1_check_req",   32'(bus.ks_req),    0);
        tick();
        chk("t1_done_valid",  32'(bus.key_valid), 1);
        chk("t1_done_key",    32'(bus.key_out),   32'hA5);
        chk("t1_done_hold",   32'(bus.dut_hold),  0);

        // 6a: reload in DONE drops the key on the next edge
        pulse_reload();
        chk("t6_reload_valid", 32'(bus.key_valid), 0);
        chk("t6_reload_key",   32'(bus.key_out),   0);
        chk("t6_reload_hold",  32'(bus.dut_hold),  1);

        // 2: bad parity, then good 3C. ks_vld during CHECK/IDLE must be ignored.
        send_frame(8'h3C, 1'b1, 9, 0, -1);
        chk("t2_check_req", 32'(bus.ks_req), 0);
        bus.ks_vld = 1'b1;
        bus.ks_bit = 1'b1;
        tick();
        chk("t2_idle_req", 32'(bus.ks_req), 0);
        tick();
        chk("t2_refetch_req", 32'(bus.ks_req), 1);
        bus.ks_vld = 1'b0;
        bus.ks_bit = 1'b0;
        push_exp(1'b0, 8'h3C);
        send_frame(8'h3C, 1'b0, 9, 0, -1);
        repeat (2) tick();
        chk("t2_key_error", 32'(bus.key_error), 0);

        // 3: three bad frames exhaust the retries
        pulse_reload();
        push_exp(1'b1, 8'h00);
        for (int n = 0; n < 3; n++) begin
            send_frame(8'h11, 1'b1, 9, 0, -1);
        end
        any_req = 1'b0;
        repeat (12) begin
            tick();
            any_req |= bus.ks_req;
        end
        chk("t3_no_req",    32'(any_req),        0);
        chk("t3_key_error", 32'(bus.key_error),  1);
        chk("t3_hold",      32'(bus.dut_hold),   1);

        // 6b: reload in FAIL
        pulse_reload();
`ifdef LOCK_KEY_LOADER_LOCKOUT_EN
        repeat (4) tick();
        chk("t6_fail_sticky_err", 32'(bus.key_error), 1);
        chk("t6_fail_sticky_req", 32'(bus.ks_req),    0);
`else
        chk("t6_fail_clear_err", 32'(bus.key_error), 0);
        tick();
        chk("t6_fail_refetch_req", 32'(bus.ks_req), 1);
`endif

        // 4: timeout after beat 3 counts as one retry; two more bad frames -> FAIL
        rst = 1'b1;
        tick();
        rst = 1'b0;
        push_exp(1'b1, 8'h00);
        send_frame(8'h5A, 1'b0, 3, 0, -1);
        repeat (15) tick();
        chk("t4_req_before_tmo", 32'(bus.ks_req), 1);
        tick();
        chk("t4_req_at_tmo", 32'(bus.ks_req), 0);
        tick();
        chk("t4_idle_req", 32'(bus.ks_req),    0);
        chk("t4_no_error", 32'(bus.key_error), 0);
        send_frame(8'h5A, 1'b1, 9, 0, -1);
        send_frame(8'h5A, 1'b1, 9, 0, -1);
        repeat (3) tick();
        chk("t4_fail_error", 32'(bus.key_error), 1);

        // 5: rst mid-SHIFT after 5 beats, then a fresh 81 load
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send_frame(8'hFF, 1'b0, 5, 0, -1);
        rst = 1'b1;
        #1;
        chk_reset_vals("t5_async_rst");
        tick();
        rst = 1'b0;
        push_exp(1'b0, 8'h81);
        send_frame(8'h81, 1'b0, 9, 0, -1);
        repeat (2) tick();
        chk("t5_key", 32'(bus.key_out), 32'h81);

        // Boundary: reload mid-fetch ignored, parity beat on the timeout cycle wins
        pulse_reload();
        push_exp(1'b0, 8'hC3);
        send_frame(8'hC3, 1'b0, 9, 15, 2);
        repeat (2) tick();
        chk("bnd_valid", 32'(bus.key_valid), 1);
        chk("bnd_key",   32'(bus.key_out),   32'hC3);

        repeat (4) tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
